// File: rtl/muldiv_iterative.sv
// muldiv_iterative
// Multi-cycle RV32M multiply/divide unit sitting between the register file
// read ports (RD1/RD2) and its write port (AD3/WE3/WD3). Operands are
// captured on a start pulse and the unit retires one bit per cycle
// (shift-add multiply, restoring shift-subtract divide), then issues a
// single-cycle write-back request.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    operation request, sampled only in IDLE
//   op       funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rs1_val  operand A
//   rs2_val  operand B
//   rd_addr  destination register
//   busy     high from the cycle after start is accepted through DONE
//   wb_we    one-cycle write enable (never asserted for x0)
//   wb_addr  write-back register address
//   wb_data  write-back value; holds the last result until the next DONE
//
// Build option:
//   MULDIV_SIGNED_EN  when defined, MULH/MULHSU/DIV/REM use signed operands
//                     (magnitude iteration plus sign fix-up). When undefined
//                     they behave as their unsigned counterparts and no sign
//                     logic is built.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one iteration step per cycle, count down from DATA_WIDTH
// DONE  | write-back cycle, back to IDLE next

module muldiv_iterative #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [DATA_WIDTH-1:0]    rs1_val,
  input  logic [DATA_WIDTH-1:0]    rs2_val,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     busy,
  output logic                     wb_we,
  output logic [ADDRESS_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]    wb_data
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]               state;
  logic [2:0]               op_q;
  logic [ADDRESS_WIDTH-1:0] rd_q;
  logic [W-1:0]             hi, lo, b_reg;
  logic [CW-1:0]            count;

  logic [W-1:0] a_mag, b_mag;
`ifdef MULDIV_SIGNED_EN
  logic sa, sb;
  logic neg_q, neg_r;   // negate product/quotient, negate remainder
`endif

  // Operand magnitudes; signed operands are folded to magnitude on entry.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    sa    = rs1_val[W-1] & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
    sb    = rs2_val[W-1] & (op == 3'b001 || op == 3'b100 || op == 3'b110);
    a_mag = sa ? -rs1_val : rs1_val;
    b_mag = sb ? -rs2_val : rs2_val;
`else
    a_mag = rs1_val;
    b_mag = rs2_val;
`endif
  end

  // One iteration step. Multiply: {hi,lo} holds partial product with the
  // multiplier shifting out of lo. Divide: hi is the partial remainder,
  // lo shifts the dividend out and the quotient bits in.
  logic [W:0]   mul_sum, div_sh, div_diff;
  logic         div_ge;
  logic [W-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_reg} : '0);
    div_sh   = {hi, lo[W-1]};
    div_diff = div_sh - {1'b0, b_reg};
    div_ge   = (div_sh >= {1'b0, b_reg});
    if (op_q[2]) begin
      step_hi = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
      step_lo = {lo[W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], lo[W-1:1]};
    end
  end

  // Result of the final step, with sign fix-up when enabled.
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem, result;

  always_comb begin
    prod = {step_hi, step_lo};
    quo  = step_lo;
    rem  = step_hi;
`ifdef MULDIV_SIGNED_EN
    if (neg_q) begin
      prod = -prod;
      quo  = -quo;
    end
    if (neg_r) rem = -rem;
`endif
    case (op_q)
      3'b000:                 result = prod[W-1:0];
      3'b001, 3'b010, 3'b011: result = prod[2*W-1:W];
      3'b100, 3'b101:         result = quo;
      default:                result = rem;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      hi      <= '0;
      lo      <= '0;
      b_reg   <= '0;
      count   <= '0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`endif
    end else begin
      wb_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            rd_q  <= rd_addr;
            hi    <= '0;
            lo    <= a_mag;
            b_reg <= b_mag;
`ifdef MULDIV_SIGNED_EN
            neg_q <= sa ^ sb;
            neg_r <= sa;
`endif
            if (op[2] && rs2_val == '0) begin
              // Divide by zero bypasses iteration: all ones / dividend.
              state   <= S_DONE;
              wb_we   <= (rd_addr != '0);
              wb_addr <= rd_addr;
              wb_data <= op[1] ? rs1_val : '1;
            end else begin
              state <= S_RUN;
              count <= CW'(DATA_WIDTH);
            end
          end
        end
        S_RUN: begin
          hi    <= step_hi;
          lo    <= step_lo;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state   <= S_DONE;
            wb_we   <= (rd_q != '0);
            wb_addr <= rd_q;
            wb_data <= result;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
